pi_point_tally: RTL

- Downstream consumer of the lfsr18 random source in the Monte Carlo pi simulator.
- Each accepted 18-bit random word is split into an (x,y) point in the unit quarter-square.
- A pipeline classifies each point as inside or outside the quarter circle.
- Counters accumulate total and inside hits for the pi estimate, and each classified point is streamed to the VGA pixel plotter over valid/ready.

---
 rtl/pi_sim_pkg.sv | 10 +
 rtl/pi_inside_pipe.sv | 57 +++++
 rtl/pi_point_tally.sv | 78 +++++++
 3 files changed

// File: rtl/pi_sim_pkg.sv
// pi_sim_pkg: shared widths, FSM states and circle-threshold helper for the Monte Carlo pi tally
package pi_sim_pkg;
  localparam int COORD_W = 9;
  localparam int CNT_W = 32;
  localparam int THRESH_BIT = 2 * COORD_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  function automatic int thresh_bit(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/pi_inside_pipe.sv
// pi_inside_pipe: coords -> squares -> quarter-circle compare, all stages share one advance enable
module pi_inside_pipe
  import pi_sim_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  input  logic         in_valid,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         s0_valid,
  output logic         s1_valid,
  output logic         out_valid,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic         out_inside
);
  localparam int TB = thresh_bit(W);
  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, in2_q, in2_d;
  logic [W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [2*W-1:0] xx_q, xx_d, yy_q, yy_d;
  logic [2*W:0] sum;
  always_comb begin
    sum = {1'b0, xx_q} + {1'b0, yy_q};
    v0_d = advance ? in_valid : v0_q;
    x0_d = advance ? in_x : x0_q;
    y0_d = advance ? in_y : y0_q;
    v1_d = advance ? v0_q : v1_q;
    x1_d = advance ? x0_q : x1_q;
    y1_d = advance ? y0_q : y1_q;
    xx_d = advance ? (2*W)'(x0_q) * (2*W)'(x0_q) : xx_q;
    yy_d = advance ? (2*W)'(y0_q) * (2*W)'(y0_q) : yy_q;
    v2_d = advance ? v1_q : v2_q;
    x2_d = advance ? x1_q : x2_q;
    y2_d = advance ? y1_q : y2_q;
    in2_d = advance ? !sum[TB] : in2_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {v0_q, v1_q, v2_q, in2_q} <= '0;
      {x0_q, y0_q, x1_q, y1_q, x2_q, y2_q} <= '0;
      {xx_q, yy_q} <= '0;
    end else begin
      {v0_q, v1_q, v2_q, in2_q} <= {v0_d, v1_d, v2_d, in2_d};
      {x0_q, y0_q, x1_q, y1_q, x2_q, y2_q} <= {x0_d, y0_d, x1_d, y1_d, x2_d, y2_d};
      {xx_q, yy_q} <= {xx_d, yy_d};
    end
  end
  assign s0_valid = v0_q;
  assign s1_valid = v1_q;
  assign out_valid = v2_q;
  assign out_x = x2_q;
  assign out_y = y2_q;
  assign out_inside = in2_q;
endmodule

// File: rtl/pi_point_tally.sv
// pi_point_tally: run FSM, LFSR issue control and hit tallies around pi_inside_pipe.
// Define PI_TALLY_BACKPRESSURE_EN to honour out_ready; otherwise the pipeline never stalls.
module pi_point_tally
  import pi_sim_pkg::*;
#(
  parameter int COORD_W = pi_sim_pkg::COORD_W,
  parameter int CNT_W = pi_sim_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  input  logic [2*COORD_W-1:0] rand_q,
  output logic                 rand_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COORD_W-1:0]   out_x,
  output logic [COORD_W-1:0]   out_y,
  output logic                 out_inside,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [CNT_W-1:0]     inside_cnt,
  output logic                 busy,
  output logic                 done
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d, target_q, target_d, total_q, total_d, inside_q, inside_d;
  logic busy_q, busy_d, done_q, done_d;
  logic rdy, adv, acc, v0, v1;
`ifdef PI_TALLY_BACKPRESSURE_EN
  assign rdy = out_ready;
`else
  assign rdy = 1'b1 | out_ready;
`endif
  assign adv = !out_valid | rdy;
  assign acc = out_valid & rdy;
  assign rand_en = (state_q == RUN) && adv && (issued_q < target_q);
  pi_inside_pipe #(.W(COORD_W)) u_pipe (
    .clk(clk), .reset(reset), .advance(adv), .in_valid(rand_en),
    .in_x(rand_q[2*COORD_W-1:COORD_W]), .in_y(rand_q[COORD_W-1:0]),
    .s0_valid(v0), .s1_valid(v1), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .out_inside(out_inside)
  );
  always_comb begin
    state_d = state_q;
    issued_d = issued_q + CNT_W'(rand_en);
    target_d = target_q;
    total_d = total_q + CNT_W'(acc);
    inside_d = inside_q + CNT_W'(acc & out_inside);
    if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d = (n_samples == '0) ? DONE : RUN;
      issued_d = '0;
      target_d = n_samples;
      total_d = '0;
      inside_d = '0;
    end else if (state_q == RUN && rand_en && issued_d == target_q) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && acc && !v0 && !v1) begin
      state_d = DONE;
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      {issued_q, target_q, total_q, inside_q} <= '0;
      {busy_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      {issued_q, target_q, total_q, inside_q} <= {issued_d, target_d, total_d, inside_d};
      {busy_q, done_q} <= {busy_d, done_d};
    end
  end
  assign total_cnt = total_q;
  assign inside_cnt = inside_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
